// File: rtl/sample_frame_buffer.sv
// rtl/sample_frame_buffer.sv - two-bank ping-pong sample buffer draining I/Q pairs to a ready/valid reader
module sample_frame_buffer #(
  parameter int FW = 5
) (
  input  logic        dsp_clk,
  input  logic        rst,
  input  logic [15:0] write_data,
  input  logic [15:0] write_addr,
  input  logic        write_en_in,
  output logic [15:0] out_i,
  output logic [15:0] out_q,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [1:0]  bank_full,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  localparam int AW = FW + 1;
  localparam int PW = (FW > 1) ? FW - 1 : 1;
  localparam logic [PW-1:0] P_LAST = PW'((2 ** (FW - 1)) - 1);

  typedef enum logic [1:0] {IDLE, RD_I, RD_Q, HOLD} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_rd_bank;
  logic [PW-1:0]  r_pair;
  logic [15:0]    r_mem [2 ** AW];
  logic [15:0]    r_ram_rd;
  logic [15:0]    r_out_i;
  logic [1:0]     r_full;
  logic           r_overflow;
  logic [7:0]     r_drops;

  logic           w_wbank;
  logic           w_woff_last;
  logic           w_wr_ok;
  logic           w_wr_drop;
  logic           w_pair_last;
  logic           w_xfer;
  logic           w_release;
  logic           w_rd_en;
  logic [AW-1:0]  w_rd_addr;
  logic [1:0]     w_set;
  logic [1:0]     w_clr;
  logic           w_unused_addr;

  assign w_unused_addr = &{1'b0, write_addr[15:FW+1]};

  // Acceptance looks at the flag as it stood before this edge, so a bank
  // released on this same edge still drops the write.
  assign w_wbank     = write_addr[FW];
  assign w_woff_last = &write_addr[FW-1:0];
  assign w_wr_ok     = write_en_in & ~r_full[w_wbank];
  assign w_wr_drop   = write_en_in & r_full[w_wbank];
  assign w_pair_last = (r_pair == P_LAST);
  assign w_xfer      = (r_state == HOLD) & out_ready;
  assign w_release   = w_xfer & w_pair_last;
  assign w_set       = (w_wr_ok & w_woff_last) ? (2'b01 << w_wbank) : 2'b00;
  assign w_clr       = w_release ? (2'b01 << r_rd_bank) : 2'b00;

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_rd_addr   = {r_rd_bank, {FW{1'b0}}} | AW'({r_pair, 1'b0});
    case (r_state)
      IDLE: if (r_full[r_rd_bank]) w_state_nxt = RD_I;
      RD_I: begin
        w_rd_en     = 1'b1;
        w_state_nxt = RD_Q;
      end
      RD_Q: begin
        w_rd_en      = 1'b1;
        w_rd_addr[0] = 1'b1;
        w_state_nxt  = HOLD;
      end
      HOLD: if (out_ready) w_state_nxt = w_pair_last ? IDLE : RD_I;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge dsp_clk) begin
    if (!rst && w_wr_ok) r_mem[write_addr[FW:0]] <= write_data;
  end

  // The read register doubles as out_q; it only moves in RD_I/RD_Q so it is stable in HOLD.
  always_ff @(posedge dsp_clk) begin
    if (rst)          r_ram_rd <= 16'h0000;
    else if (w_rd_en) r_ram_rd <= r_mem[w_rd_addr];
  end

  always_ff @(posedge dsp_clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rd_bank  <= 1'b0;
      r_pair     <= '0;
      r_out_i    <= 16'h0000;
      r_full     <= 2'b00;
      r_overflow <= 1'b0;
      r_drops    <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_full  <= (r_full & ~w_clr) | w_set;
      if (r_state == RD_Q) r_out_i <= r_ram_rd;
      if (w_xfer) r_pair <= w_pair_last ? '0 : r_pair + 1'b1;
      if (w_release) r_rd_bank <= ~r_rd_bank;
      if (w_wr_drop) begin
        r_overflow <= 1'b1;
        if (r_drops != 8'hFF) r_drops <= r_drops + 8'h01;
      end
    end
  end

  assign out_valid  = (r_state == HOLD);
  assign out_last   = out_valid & w_pair_last;
  assign out_i      = r_out_i;
  assign out_q      = r_ram_rd;
  assign bank_full  = r_full;
  assign overflow   = r_overflow;
  assign drop_count = r_drops;

endmodule

// File: doc/sample_frame_buffer.md
SAMPLE_FRAME_BUFFER -- requirements
Module: sample_frame_buffer

Interface
REQ-001 Parameter FW, default 5: log2 of the frame length in 16-bit words; legal range 1..14.
REQ-002 Port dsp_clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port write_data, input, 16: sample word from the receiver input stage.
REQ-005 Port write_addr, input, 16: write address; bits [FW-1:0] are the word offset, bit [FW] is the bank select, higher bits are ignored.
REQ-006 Port write_en_in, input, 1: write strobe; one word is written per cycle when high.
REQ-007 Port out_i, output, 16: in-phase word of the current output pair.
REQ-008 Port out_q, output, 16: quadrature word of the current output pair.
REQ-009 Port out_valid, output, 1: output pair is valid.
REQ-010 Port out_ready, input, 1: downstream DSP accepts the pair.
REQ-011 Port out_last, output, 1: current pair is the final pair of its frame.
REQ-012 Port bank_full, output, 2: per-bank full flags.
REQ-013 Port overflow, output, 1: sticky flag; set when any write is dropped.
REQ-014 Port drop_count, output, 8: count of dropped writes, saturating at 255.

Function
REQ-015 Storage: two banks of 2^FW x 16-bit words. Synchronous-read RAM with 1-cycle read latency.
REQ-016 Word layout: even offsets hold I, odd offsets hold Q. Pair p = words (2p, 2p+1). A frame holds 2^(FW-1) pairs.
REQ-017 Write acceptance: a write is accepted only when write_en_in=1 and bank_full[bank] was 0 at the start of that cycle.
REQ-018 Dropped writes: a write with write_en_in=1 to a bank whose flag is set is not stored. It sets overflow and increments drop_count (saturating).
REQ-019 Full flag set: an accepted write at offset 2^FW-1 sets bank_full[bank] on that same edge.
REQ-020 Full flag clear: bank_full[b] clears on the edge that transfers the last pair of bank b.
REQ-021 Same-cycle set and clear: if bank b is released on the same edge as a write to bank b, the write is dropped (see REQ-017). Set and clear on different banks on the same edge are independent.
REQ-022 Read bank pointer rd_bank: resets to 0. The reader serves only rd_bank. rd_bank toggles when the bank is released.
REQ-023 Reader FSM states are IDLE, RD_I, RD_Q and HOLD.
  - IDLE -> RD_I when bank_full[rd_bank]=1.
  - RD_I presents the I address for pair p, then -> RD_Q.
  - RD_Q captures I and presents the Q address, then -> HOLD.
  - HOLD captures Q on entry, and out_valid=1 while in HOLD.
REQ-024 Latency: if a full flag is set on edge k, out_valid rises after edge k+3 (IDLE at k+1 sees the flag, RD_I at k+1, RD_Q at k+2, HOLD at k+3).
REQ-025 Handshake: a transfer occurs on an edge where out_valid=1 and out_ready=1. While out_valid=1 and out_ready=0, out_i, out_q and out_last hold stable.
REQ-026 After a transfer of a pair that is not the last pair: p increments, the FSM goes to RD_I, and out_valid=0 for 2 cycles. Maximum throughput is one pair per 3 cycles.
REQ-027 After a transfer of the last pair: the bank is released, rd_bank toggles, p resets to 0, and the FSM goes to IDLE.
REQ-028 out_last=1 only in HOLD with p = 2^(FW-1)-1.
REQ-029 Writes to one bank while the other bank is being read are fully concurrent.
REQ-030 out_ready is ignored when out_valid=0.

Reset
REQ-031 While rst=1 on an edge, the following take their reset values:
  - state=IDLE, rd_bank=0, p=0
  - bank_full=2'b00
  - out_valid=0, out_last=0, out_i=16'h0000, out_q=16'h0000
  - overflow=0, drop_count=0
REQ-032 Reset mid-frame (partial writes or partial reads) discards all frame progress. RAM contents are not cleared. The first post-reset output comes only from a newly completed frame.
REQ-033 Writes and handshakes presented in the same cycle as rst=1 have no effect.

Verification
REQ-034 Basic frame (FW=2): write 1111,2222,3333,4444 to addresses 0..3, out_ready=1.
  -> bank_full=01 after the 4th write.
  -> out_valid rises 3 edges later with (I=1111, Q=2222, last=0).
  -> next pair (I=3333, Q=4444, last=1) after 3 more cycles.
  -> bank_full returns to 00.
REQ-035 Backpressure: hold out_ready=0 for 10 cycles in HOLD -> out_i, out_q and out_last remain stable; exactly one transfer occurs when out_ready rises.
REQ-036 Ping-pong: fill bank 0 (addresses 0..3), then bank 1 (addresses 4..7) while bank 0 is read -> pairs emerge in bank 0 order, then bank 1 order; no drops.
REQ-037 Overflow: fill both banks with out_ready=0, then write 3 more words to address 0 -> no RAM change (first pair still reads its original value), overflow=1, drop_count=3; drop_count saturates at 255 after 300 drops.
REQ-038 Same-edge release and write: issue a write to bank 0 on the edge that transfers bank 0's last pair -> write dropped, drop_count increments by 1, bank_full[0]=0 afterwards.
REQ-039 Reset mid-read: assert rst for 1 cycle while in HOLD -> all outputs at reset values next cycle; no output until a new frame completes.
